// File: rtl/mem_timer_pkg.sv
// Shared definitions for the memory-mapped timer.
// Register indices, CTRL bit positions and reset values.
package mem_timer_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    // Word index taken from addr[4:2]
    localparam logic [2:0] TMR_CTRL     = 3'd0;
    localparam logic [2:0] TMR_PRESCALE = 3'd1;
    localparam logic [2:0] TMR_COUNT    = 3'd2;
    localparam logic [2:0] TMR_COMPARE  = 3'd3;
    localparam logic [2:0] TMR_STATUS   = 3'd4;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    localparam logic [DATA_W-1:0] TMR_CTRL_MASK   = 32'h0000_0007;
    localparam logic [DATA_W-1:0] TMR_COMPARE_RST = 32'hFFFF_FFFF;

    function automatic logic [DATA_W-1:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/mem_timer_bus_byte_write.sv
// 32-bit register with per-byte-lane write merge.
// Lanes not written take i_nxt (hold or computed next value).
module bus_byte_write
    import mem_timer_pkg::*;
#(
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter logic [DATA_W-1:0] MASK    = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr,
    input  logic [3:0]        i_sel,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_nxt,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_lanes;

    assign w_lanes = i_wr ? lane_mask(i_sel) : '0;
    assign o_q     = r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= (i_wdata & MASK & w_lanes) | (i_nxt & ~w_lanes);
        end
    end

endmodule

// File: rtl/mem_timer.sv
// Prescaled 32-bit timer with compare match, auto-reload and
// W1C match flag, exposed as a data-bus responder.
module mem_timer
    import mem_timer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_1000,
    parameter int                PRE_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        sel,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              int_o
);

    localparam logic [DATA_W-1:0] PRE_MASK = DATA_W'((64'd1 << PRE_W) - 64'd1);

    logic              w_hit;
    logic              w_wr;
    logic [2:0]        w_idx;
    logic              w_unused;
    logic [DATA_W-1:0] w_ctrl;
    logic [DATA_W-1:0] w_pre;
    logic [DATA_W-1:0] w_count;
    logic [DATA_W-1:0] w_cmp;
    logic [DATA_W-1:0] w_count_nxt;
    logic              w_en;
    logic              w_tick;
    logic              w_cmp_hit;
    logic              w_pre_wr;
    logic              w_clr;
    logic [PRE_W-1:0]  r_pre_cnt;
    logic              r_match;

    assign w_hit    = ce & (addr[31:5] == BASE_ADDR[31:5]);
    assign w_wr     = w_hit & we;
    assign w_idx    = addr[4:2];
    assign w_unused = &{1'b0, addr[1:0]};

    assign w_en      = w_ctrl[CTRL_EN];
    assign w_tick    = w_en & (r_pre_cnt == w_pre[PRE_W-1:0]);
    assign w_cmp_hit = (w_count == w_cmp);
    assign w_pre_wr  = w_wr & (w_idx == TMR_PRESCALE) & (|sel);
    assign w_clr     = w_wr & (w_idx == TMR_STATUS) & sel[0] & data_i[0];

    always_comb begin
        w_count_nxt = w_count;
        if (w_tick) begin
            if (w_cmp_hit && w_ctrl[CTRL_AR]) begin
                w_count_nxt = '0;
            end else begin
                w_count_nxt = w_count + 32'd1;
            end
        end
    end

    bus_byte_write #(.RST_VAL('0), .MASK(TMR_CTRL_MASK)) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr && (w_idx == TMR_CTRL)),
        .i_sel   (sel),
        .i_wdata (data_i),
        .i_nxt   (w_ctrl),
        .o_q     (w_ctrl)
    );

    bus_byte_write #(.RST_VAL('0), .MASK(PRE_MASK)) u_pre (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr && (w_idx == TMR_PRESCALE)),
        .i_sel   (sel),
        .i_wdata (data_i),
        .i_nxt   (w_pre),
        .o_q     (w_pre)
    );

    bus_byte_write #(.RST_VAL('0)) u_count (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr && (w_idx == TMR_COUNT)),
        .i_sel   (sel),
        .i_wdata (data_i),
        .i_nxt   (w_count_nxt),
        .o_q     (w_count)
    );

    bus_byte_write #(.RST_VAL(TMR_COMPARE_RST)) u_cmp (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr && (w_idx == TMR_COMPARE)),
        .i_sel   (sel),
        .i_wdata (data_i),
        .i_nxt   (w_cmp),
        .o_q     (w_cmp)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre_cnt <= '0;
        end else if (w_pre_wr) begin
            r_pre_cnt <= '0;
        end else if (w_en) begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + {{(PRE_W-1){1'b0}}, 1'b1};
        end
    end

    // A new match outranks a same-cycle W1C
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_match <= 1'b0;
        end else if (w_tick && w_cmp_hit) begin
            r_match <= 1'b1;
        end else if (w_clr) begin
            r_match <= 1'b0;
        end
    end

    always_comb begin
        data_o = '0;
        if (w_hit && !we) begin
            case (w_idx)
                TMR_CTRL:     data_o = w_ctrl;
                TMR_PRESCALE: data_o = w_pre;
                TMR_COUNT:    data_o = w_count;
                TMR_COMPARE:  data_o = w_cmp;
                TMR_STATUS:   data_o = {31'd0, r_match};
                default:      data_o = '0;
            endcase
        end
    end

    assign int_o = r_match & w_ctrl[CTRL_IE];

endmodule

// File: tb/tb_mem_timer.sv
// Directed self-checking bench for mem_timer.
// Inputs change 1 time unit after the rising edge; reads sample later.
module tb_mem_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] O_CTRL = 32'h00;
    localparam logic [31:0] O_PRE  = 32'h04;
    localparam logic [31:0] O_CNT  = 32'h08;
    localparam logic [31:0] O_CMP  = 32'h0C;
    localparam logic [31:0] O_STAT = 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_o;

    int n_err = 0;
    int n_chk = 0;

    mem_timer #(.BASE_ADDR(BASE), .PRE_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .sel    (sel),
        .data_i (data_i),
        .data_o (data_o),
        .int_o  (int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off,
                          input logic [31:0] exp);
        ce   = 1'b1;
        we   = 1'b0;
        addr = BASE + off;
        #1;
        chk(tag, data_o, exp);
        ce   = 1'b0;
    endtask

    task automatic wr_raw(input logic c, input logic [31:0] off,
                          input logic [31:0] d, input logic [3:0] s);
        ce     = c;
        we     = 1'b1;
        addr   = BASE + off;
        data_i = d;
        sel    = s;
        @(posedge clk);
        #1;
        ce     = 1'b0;
        we     = 1'b0;
        sel    = 4'h0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        wr_raw(1'b1, off, d, 4'hF);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        ce     = 1'b0;
        we     = 1'b0;
        addr   = '0;
        sel    = '0;
        data_i = '0;

        // 1: reset values
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rd_chk("rst_ctrl", O_CTRL, 32'h0);
        rd_chk("rst_pre",  O_PRE,  32'h0);
        rd_chk("rst_cnt",  O_CNT,  32'h0);
        rd_chk("rst_cmp",  O_CMP,  32'hFFFF_FFFF);
        rd_chk("rst_stat", O_STAT, 32'h0);
        rd_chk("rst_r14",  32'h14, 32'h0);
        rd_chk("rst_r1c",  32'h1C, 32'h0);
        rd_chk("rst_out20", 32'h20, 32'h0);
        rd_chk("rst_out2c", 32'h2C, 32'h0);
        chk("rst_int", {31'd0, int_o}, 32'h0);

        // 2: prescaled count and match, ticks every 4 cycles
        wr(O_PRE, 32'd3);
        wr(O_CMP, 32'd5);
        wr(O_CTRL, 32'h5);
        rd_chk("p_cnt_e0", O_CNT, 32'd0);
        cyc(3);
        rd_chk("p_cnt_e3", O_CNT, 32'd0);
        cyc(1);
        rd_chk("p_cnt_e4", O_CNT, 32'd1);
        cyc(3);
        rd_chk("p_cnt_e7", O_CNT, 32'd1);
        cyc(1);
        rd_chk("p_cnt_e8", O_CNT, 32'd2);
        cyc(15);
        rd_chk("p_cnt_e23", O_CNT, 32'd5);
        rd_chk("p_stat_e23", O_STAT, 32'd0);
        chk("p_int_e23", {31'd0, int_o}, 32'd0);
        cyc(1);
        rd_chk("p_cnt_e24", O_CNT, 32'd6);
        rd_chk("p_stat_e24", O_STAT, 32'd1);
        chk("p_int_e24", {31'd0, int_o}, 32'd1);
        wr(O_CTRL, 32'h1);
        chk("mask_int", {31'd0, int_o}, 32'd0);
        rd_chk("mask_stat", O_STAT, 32'd1);
        wr(O_CTRL, 32'h0);
        wr(O_STAT, 32'h1);
        rd_chk("w1c_stat", O_STAT, 32'd0);
        rd_chk("hold_cnt", O_CNT, 32'd6);

        // 3: auto-reload 0,1,2,0,... with W1C interaction
        wr(O_PRE, 32'd0);
        wr(O_CMP, 32'd2);
        wr(O_CNT, 32'd0);
        wr(O_CTRL, 32'h3);
        rd_chk("ar_f0", O_CNT, 32'd0);
        cyc(1);
        rd_chk("ar_f1", O_CNT, 32'd1);
        cyc(1);
        rd_chk("ar_f2", O_CNT, 32'd2);
        rd_chk("ar_f2_st", O_STAT, 32'd0);
        cyc(1);
        rd_chk("ar_f3", O_CNT, 32'd0);
        rd_chk("ar_f3_st", O_STAT, 32'd1);
        wr(O_STAT, 32'h1);
        rd_chk("ar_f4", O_CNT, 32'd1);
        rd_chk("ar_f4_st", O_STAT, 32'd0);
        cyc(1);
        rd_chk("ar_f5", O_CNT, 32'd2);
        wr(O_STAT, 32'h1);
        rd_chk("ar_f6", O_CNT, 32'd0);
        rd_chk("ar_f6_st", O_STAT, 32'd1);
        wr(O_CTRL, 32'h0);
        rd_chk("ar_lasttick", O_CNT, 32'd1);
        cyc(2);
        rd_chk("ar_stopped", O_CNT, 32'd1);

        // 4: byte lanes and non-selected writes
        wr(O_CNT, 32'd0);
        wr_raw(1'b1, O_CNT, 32'hAABB_CCDD, 4'b0101);
        rd_chk("lane_0101", O_CNT, 32'h00BB_00DD);
        wr_raw(1'b0, O_CNT, 32'hAABB_CCDD, 4'hF);
        rd_chk("lane_ce0", O_CNT, 32'h00BB_00DD);
        wr_raw(1'b1, O_CNT, 32'h1122_3344, 4'b0000);
        rd_chk("lane_sel0", O_CNT, 32'h00BB_00DD);
        wr_raw(1'b1, 32'h28, 32'h1122_3344, 4'hF);
        rd_chk("lane_miss", O_CNT, 32'h00BB_00DD);
        wr(32'h14, 32'h1234_5678);
        rd_chk("rsv_wr", 32'h14, 32'h0);
        wr(O_CTRL, 32'hFFFF_FFF8);
        rd_chk("ctrl_mask", O_CTRL, 32'h0);

        // 5: wrap past all-ones without a flag
        wr(O_STAT, 32'h1);
        wr(O_CMP, 32'h10);
        wr(O_CNT, 32'hFFFF_FFFE);
        wr(O_PRE, 32'd0);
        wr(O_CTRL, 32'h1);
        cyc(1);
        rd_chk("wrap_g1", O_CNT, 32'hFFFF_FFFF);
        cyc(1);
        rd_chk("wrap_g2", O_CNT, 32'h0);
        rd_chk("wrap_st", O_STAT, 32'h0);

        // 6: reset mid-count overrides a same-cycle write
        wr(O_CTRL, 32'h0);
        wr(O_CNT, 32'd0);
        wr(O_CMP, 32'd0);
        wr(O_CTRL, 32'h5);
        cyc(1);
        rd_chk("mid_h1", O_CNT, 32'd1);
        chk("mid_int_h1", {31'd0, int_o}, 32'd1);
        wr(O_PRE, 32'd7);
        cyc(3);
        rd_chk("mid_h5", O_CNT, 32'd2);
        rst    = 1'b0;
        ce     = 1'b1;
        we     = 1'b1;
        addr   = BASE + O_CNT;
        data_i = 32'h55;
        sel    = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b1;
        ce  = 1'b0;
        we  = 1'b0;
        sel = 4'h0;
        rd_chk("rr_cnt", O_CNT, 32'd0);
        rd_chk("rr_ctrl", O_CTRL, 32'd0);
        rd_chk("rr_cmp", O_CMP, 32'hFFFF_FFFF);
        rd_chk("rr_pre", O_PRE, 32'd0);
        chk("rr_int", {31'd0, int_o}, 32'd0);
        cyc(10);
        rd_chk("rr_idle", O_CNT, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_timer.md
Name: mem_timer

Overview:
- Memory-mapped timer/counter that acts as a responder on the CPU data-memory bus, the same ce/we/addr/sel/data interface the core drives toward data_ram.
- Sits beside data_ram in the SOPC. The top-level decodes ram_ce so that only one responder is selected per access.
- Provides a prescaled 32-bit up-counter, a compare match with optional auto-reload, a sticky match flag cleared by writing 1, and a level interrupt output for the core's interrupt input.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of register 0; aligned to 32 bytes.
- PRE_W, 16, width of the prescaler register and the prescaler counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the clk rising edge.
- ce  in  1  bus select for this responder.
- we  in  1  1 = write, 0 = read.
- addr  in  32  byte address (`DataAddrBus).
- sel  in  4  byte-lane enables; sel[0] selects data[7:0].
- data_i  in  32  write data (`DataBus).
- data_o  out  32  read data (`DataBus).
- int_o  out  1  level interrupt, equal to STATUS.match & CTRL.int_en.

Behaviour:
- Decode: hit = ce & (addr[31:5] == BASE_ADDR[31:5]). The register index is addr[4:2]; addr[1:0] is ignored.
- Register map (offset / name):
  - 0x00 CTRL: bit0 en, bit1 auto_reload, bit2 int_en; other bits read 0.
  - 0x04 PRESCALE: bits [PRE_W-1:0].
  - 0x08 COUNT.
  - 0x0C COMPARE.
  - 0x10 STATUS: bit0 match, write-1-to-clear.
  - 0x14–0x1C: reserved; read 0, writes ignored.
- Reads: combinational, zero latency, because the core's MEM stage samples data in the same cycle.
  - data_o = register value when hit & ~we; otherwise 32'h0.
  - Reads have no side effects.
- Writes: hit & we, committed at the rising edge.
  - Only lanes with sel[i]=1 update bits [8i+7:8i]. sel=4'b0000 is a no-op.
  - Writing PRESCALE also clears the prescaler counter pre_cnt to 0.
- Reset (rst==0 at an edge): CTRL=0, PRESCALE=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, pre_cnt=0.
  - As a result, data_o=0 and int_o=0.
  - Reset overrides any bus write in the same cycle.
  - A reset during counting stops the count immediately; there is no residual tick.
- Counting, when en=1:
  - Every cycle: if pre_cnt == PRESCALE then tick=1 and pre_cnt<=0; else pre_cnt<=pre_cnt+1.
  - COUNT therefore advances once every PRESCALE+1 cycles. PRESCALE=0 advances every cycle.
  - On a tick:
    - If COUNT == COMPARE: match<=1, and COUNT <= auto_reload ? 0 : COUNT+1.
    - Otherwise COUNT<=COUNT+1.
    - COUNT wraps from 32'hFFFF_FFFF to 0 with no flag, unless COMPARE equals that value.
- When en=0: pre_cnt and COUNT hold their values and no tick occurs.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick: the write wins per written byte lane; unwritten lanes take the tick result. The match test uses the pre-write COUNT.
  - A bus write to PRESCALE in the same cycle as a tick: the tick still applies to COUNT; pre_cnt becomes 0.
  - A W1C of match in the same cycle as a new match set: set wins, so match stays 1.
  - A write of CTRL.en=0 on a tick cycle: that tick still applies, because en is the registered value.
- int_o:
  - Combinational from registers only (no bus path), so it is glitch-free with respect to bus inputs.
  - Clearing int_en masks int_o without clearing match.

Decomposition:
- Shared defines header:
  - Register offsets TMR_CTRL, TMR_PRESCALE, TMR_COUNT, TMR_COMPARE, TMR_STATUS.
  - CTRL bit positions.
  - Reset value TMR_COMPARE_RST.
  - The existing `DataBus/`DataAddrBus widths.
- One natural sub-module, bus_byte_write: a 32-bit register with a per-lane sel write merge. Instantiate it for CTRL, PRESCALE, COUNT and COMPARE. COUNT's next-value mux feeds it the tick value for lanes that are not written.

Test Plan:
1. Reset with rst=0 for 2 cycles, then read all offsets. Required: CTRL/PRESCALE/COUNT/STATUS=0, COMPARE=32'hFFFF_FFFF, int_o=0. A read at BASE_ADDR+0x20 returns 0.
2. Write PRESCALE=3, COMPARE=5, CTRL=3'b101, then poll. Required: COUNT increments every 4 cycles. match=1 and int_o=1 on the tick where COUNT==5, and COUNT reads 6 afterward.
3. Auto-reload with PRESCALE=0, COMPARE=2, CTRL=3'b011. Required: COUNT sequence 0,1,2,0,1,2… and match set on the first wrap. A W1C to STATUS (data_i=1) on a non-match cycle clears it; a W1C coinciding with a match leaves match=1.
4. Byte lanes: with COUNT=0 and en=0, write data_i=32'hAABBCCDD with sel=4'b0101. Required: COUNT reads 32'h00BB00DD. With ce=0 and the same write, there is no change.
5. Wrap: set COUNT=32'hFFFF_FFFE, COMPARE=0x10, en=1, PRESCALE=0. Required: after 2 cycles COUNT=0 with match still 0.
6. Reset mid-count: pulse rst=0 for one edge while counting with PRESCALE=7 and pre_cnt mid-way. Required: next cycle COUNT=0, en=0, int_o=0, and no further increments.
